// File: rtl/iterative_divider.sv
// -----------------------------------------------------------------------------
// iterative_divider
//   Multi-cycle restoring shift-and-subtract divider for UDIV/SDIV.
//   One quotient bit is produced per cycle. Signed operands are reduced to
//   magnitudes up front, and the signs are re-applied in a single fix-up cycle.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        one-cycle request, honoured only when idle
//   is_signed    1 = SDIV (two's complement), 0 = UDIV
//   dividend     numerator, sampled with start
//   divisor      denominator, sampled with start
//   busy         high while a division is in progress (RUN and FIX)
//   done         one-cycle pulse when the results become valid
//   quotient     result quotient, held until the next completion
//   remainder    result remainder, held until the next completion
//   div_by_zero  set when the last completed operation had a zero divisor
// -----------------------------------------------------------------------------
module iterative_divider #(
  parameter int N  = 64,
  parameter int CW = 7
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's complement negation; the most-negative value maps onto itself,
  // which is what makes most-negative / -1 come out as most-negative.
  function automatic logic [N-1:0] f_neg(input logic [N-1:0] x);
    f_neg = ~x + 1'b1;
  endfunction

  function automatic logic [N-1:0] f_mag(input logic [N-1:0] x, input logic sgn);
    f_mag = (sgn && x[N-1]) ? f_neg(x) : x;
  endfunction

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_dbz;
  logic [N-1:0]   r_quot;
  logic [N-1:0]   r_remd;

  logic [N-1:0]   r_rem;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_dvsr;
  logic           r_sign_q;
  logic           r_sign_r;

  logic [N:0]     w_shift;
  logic           w_ge;
  logic [N-1:0]   w_trial;
  logic           w_divz;
  logic           w_accept;

  // The shifted partial remainder needs N+1 bits because an unsigned divisor
  // may use the full N bits. When it is not smaller than the divisor the
  // difference always fits back into N bits.
  assign w_shift  = {r_rem, r_q[N-1]};
  assign w_ge     = (w_shift >= {1'b0, r_dvsr});
  assign w_trial  = w_shift[N-1:0] - r_dvsr;
  assign w_divz   = (divisor == '0);
  assign w_accept = (r_state == S_IDLE) && start;

  // Control and architecturally visible results
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (w_divz) begin
              // Divide-by-zero completes immediately with ARMv8 results.
              r_quot  <= '0;
              r_remd  <= dividend;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt   <= CW'(N);
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_quot  <= r_sign_q ? f_neg(r_q)   : r_q;
          r_remd  <= r_sign_r ? f_neg(r_rem) : r_rem;
          r_dbz   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Iteration datapath: only meaningful between an accepted start and FIX
  always_ff @(posedge clock) begin
    if (w_accept && !w_divz) begin
      r_rem    <= '0;
      r_q      <= f_mag(dividend, is_signed);
      r_dvsr   <= f_mag(divisor, is_signed);
      r_sign_q <= is_signed & (dividend[N-1] ^ divisor[N-1]);
      r_sign_r <= is_signed & dividend[N-1];
    end else if (r_state == S_RUN) begin
      r_rem <= w_ge ? w_trial : w_shift[N-1:0];
      r_q   <= {r_q[N-2:0], w_ge};
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remd;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_iterative_divider.sv
module tb_iterative_divider;

  localparam int N = 64;
  localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic         is_signed;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_vec;
  int n_err;
  logic [63:0] prev_q;

  iterative_divider #(.N(N), .CW(7)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: language-level division with the ARMv8 special cases.
  function automatic void model(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r, output logic z);
    longint sa;
    longint sb;
    z = 1'b0;
    if (b == 64'd0) begin
      q = 64'd0;
      r = a;
      z = 1'b1;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == MOST_NEG && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q = MOST_NEG;
      r = 64'd0;
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      q = 64'(sa / sb);
      r = 64'(sa % sb);
    end
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v;
  endfunction

  // Issue one division and follow it to completion. With spam set, extra
  // starts with unrelated operands are pulsed while the unit is busy.
  task automatic run_div(input string tag, input logic sgn, input logic [63:0] a,
                         input logic [63:0] b, input bit spam);
    logic [63:0] eq, er;
    logic        ez;
    int          k, exp_lat, bad_busy, extra_done;
    bit          got;
    model(sgn, a, b, eq, er, ez);
    exp_lat = ez ? 1 : N + 2;
    @(negedge clock);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    k = 0; got = 0; bad_busy = 0; extra_done = 0;
    while (!got && k < 200) begin
      @(negedge clock);
      k++;
      if (done) got = 1;
      else if (busy !== (k < exp_lat)) bad_busy++;
      if (k == 30 && exp_lat > 30) chk({tag, "_hold_q"}, quotient, prev_q);
      if (spam && !got && k < exp_lat - 2 && (k % 3 == 0)) begin
        start = 1'b1; is_signed = ~sgn; dividend = rnd64(); divisor = rnd64() | 64'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(bad_busy), 64'd0);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, ez});
    chk({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    repeat (4) begin
      @(negedge clock);
      if (done || busy) extra_done++;
    end
    chk({tag, "_one_done"}, 64'(extra_done), 64'd0);
    prev_q = eq;
  endtask

  initial begin
    int bad;
    logic        sg;
    logic [63:0] a, b;
    n_vec = 0; n_err = 0; prev_q = 64'd0;
    reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;

    repeat (3) @(negedge clock);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_q", quotient, 64'd0);
    chk("rst_r", remainder, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    reset_n = 1'b1;

    // Directed cases
    run_div("u100_7", 1'b0, 64'd100, 64'd7, 1'b0);
    run_div("s-100_7", 1'b1, -64'sd100, 64'd7, 1'b0);
    run_div("s100_-7", 1'b1, 64'd100, -64'sd7, 1'b0);
    run_div("s-100_-7", 1'b1, -64'sd100, -64'sd7, 1'b0);
    run_div("dbz", 1'b0, 64'h1234, 64'd0, 1'b0);
    run_div("u8_2", 1'b0, 64'd8, 64'd2, 1'b0);
    run_div("umax_1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    run_div("sovf", 1'b1, MOST_NEG, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_div("u5_9", 1'b0, 64'd5, 64'd9, 1'b0);
    run_div("umax_umax1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_div("spam", 1'b0, 64'd1000, 64'd33, 1'b1);

    // Randomized cases
    for (int i = 0; i < 24; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = rnd64();
      b  = rnd64();
      if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(0, 62);
      if ($urandom_range(0, 2) != 0) b = b >> $urandom_range(30, 63);
      if (sg && $urandom_range(0, 1) == 1) b = -b;
      if ($urandom_range(0, 9) == 0) b = 64'd0;
      run_div($sformatf("rnd%0d", i), sg, a, b, bit'($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a division
    @(negedge clock);
    start = 1'b1; is_signed = 1'b0; dividend = 64'd999; divisor = 64'd10;
    @(negedge clock);
    start = 1'b0;
    repeat (29) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_q", quotient, 64'd0);
    chk("arst_r", remainder, 64'd0);
    chk("arst_dbz", {63'd0, div_by_zero}, 64'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy) bad++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (done || busy) bad++;
    end
    chk("arst_quiet", 64'(bad), 64'd0);
    prev_q = 64'd0;
    run_div("post_rst", 1'b1, -64'sd12345, 64'd100, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
